io_bridge_arb: RTL and testbench

Parametrised successor of the single-port I/O bridge. Accepts NMST Wishbone-classic slave ports from CPUs/DMA and filters each request against a programmable I/O address window. Arbitrates round-robin among the ports and drives one registered master port to the I/O device tree. Adds a bus-timeout watchdog and error return that the previous bridge lacked, so a dead device cannot hang a CPU.

---
 rtl/io_bridge_arb.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_io_bridge_arb.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge_arb.sv
// io_bridge_arb: multi-port Wishbone-classic bridge onto the I/O device tree.
// Filters requests against an address window, arbitrates round-robin, drives
// one registered master port and returns an error if the device never answers.
module io_bridge_arb #(
  parameter int unsigned NMST    = 2,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter logic [31:0] IO_BASE = 32'hFD000000,
  parameter logic [31:0] IO_MASK = 32'hFF000000,
  parameter int unsigned TMO     = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   gate_en_i,
  input  logic [NMST-1:0]        s_cyc_i,
  input  logic [NMST-1:0]        s_stb_i,
  input  logic [NMST-1:0]        s_we_i,
  input  logic [NMST*DW/8-1:0]   s_sel_i,
  input  logic [NMST*AW-1:0]     s_adr_i,
  input  logic [NMST*DW-1:0]     s_dat_i,
  output logic [NMST-1:0]        s_ack_o,
  output logic [NMST-1:0]        s_err_o,
  output logic [NMST*DW-1:0]     s_dat_o,
  output logic                   m_cyc_o,
  output logic                   m_stb_o,
  output logic                   m_we_o,
  output logic [DW/8-1:0]        m_sel_o,
  output logic [AW-1:0]          m_adr_o,
  output logic [DW-1:0]          m_dat_o,
  input  logic                   m_ack_i,
  input  logic                   m_err_i,
  input  logic [DW-1:0]          m_dat_i,
  output logic                   busy_o
);

  localparam int unsigned SW  = DW / 8;
  localparam int unsigned PW  = (NMST > 1) ? $clog2(NMST) : 1;
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned TW  = (TMO > 0) ? $clog2(TMO + 1) : 1;

  localparam logic [AW-1:0]  BASE_W   = AW'(IO_BASE);
  localparam logic [AW-1:0]  MASK_W   = AW'(IO_MASK);
  localparam logic [PW-1:0]  LAST_P   = PW'(NMST - 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_NACK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   g_q, g_d, rr_q, rr_d, pick, ld_port, g_inc;
  logic [PW1-1:0]  cand;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            hold_q, hold_d;
  logic [NMST-1:0] req;
  logic            pick_vld, grant_ok, tmo_hit;
  logic            g_cyc, g_stb, g_req;
  logic            ld_we;
  logic [SW-1:0]   ld_sel;
  logic [AW-1:0]   ld_adr;
  logic [DW-1:0]   ld_dat;

  logic            load, bus_clr, rsp_set, rsp_ack;
  logic [DW-1:0]   rsp_dat;
  logic            m_cyc_d, m_stb_d, m_we_d;
  logic [SW-1:0]   m_sel_d;
  logic [AW-1:0]   m_adr_d;
  logic [DW-1:0]   m_dat_d;
  logic [NMST-1:0] s_ack_d, s_err_d;
  logic [NMST*DW-1:0] s_dat_d;
  logic            busy_d;

  // Per-port request: active cycle+strobe whose address falls in the I/O window
  always_comb begin
    req = '0;
    for (int p = 0; p < NMST; p++) begin
      req[p] = s_cyc_i[p] & s_stb_i[p] &
               ((s_adr_i[p*AW +: AW] & MASK_W) == BASE_W);
    end
  end

  // Round-robin search: first requesting port at or after rr_q, wrapping
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int i = NMST - 1; i >= 0; i--) begin
      cand = {1'b0, rr_q} + PW1'(i);
      if (cand >= PW1'(NMST)) cand = cand - PW1'(NMST);
      if ((req & (NMST'(1) << cand)) != '0) begin
        pick_vld = 1'b1;
        pick     = cand[PW-1:0];
      end
    end
  end

  assign ld_port  = (state_q == IDLE) ? pick : g_q;
  assign g_inc    = (g_q == LAST_P) ? '0 : g_q + PW'(1);
  assign grant_ok = gate_en_i & ~m_ack_i & pick_vld;
  assign tmo_hit  = (TMO != 0) && (tmo_q == TMO_LAST);

  // Select the granted port's handshake and the fields to load onto the bus
  always_comb begin
    g_cyc  = 1'b0;
    g_stb  = 1'b0;
    g_req  = 1'b0;
    ld_we  = 1'b0;
    ld_sel = '0;
    ld_adr = '0;
    ld_dat = '0;
    for (int p = 0; p < NMST; p++) begin
      if (PW'(p) == g_q) begin
        g_cyc = s_cyc_i[p];
        g_stb = s_stb_i[p];
        g_req = req[p];
      end
      if (PW'(p) == ld_port) begin
        ld_we  = s_we_i[p];
        ld_sel = s_sel_i[p*SW +: SW];
        ld_adr = s_adr_i[p*AW +: AW];
        ld_dat = s_dat_i[p*DW +: DW];
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a port still holding cyc after its stb handshake keeps
  // the bridge locked in WAIT_NACK so its follow-up access is not interleaved
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_ok) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (m_ack_i || m_err_i || tmo_hit) state_d = WAIT_NACK;
        else if (!g_cyc)                   state_d = IDLE;
      end
      WAIT_NACK: begin
        if (hold_q) begin
          if (!g_stb && !g_cyc) state_d = IDLE;
        end else if (g_req) begin
          state_d = WAIT_ACK;
        end else if (!g_cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output
  always_comb begin
    g_d     = g_q;
    rr_d    = rr_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    m_cyc_d = m_cyc_o;
    m_stb_d = m_stb_o;
    m_we_d  = m_we_o;
    m_sel_d = m_sel_o;
    m_adr_d = m_adr_o;
    m_dat_d = m_dat_o;
    s_ack_d = s_ack_o;
    s_err_d = s_err_o;
    s_dat_d = s_dat_o;
    busy_d  = (state_d != IDLE);
    load    = 1'b0;
    bus_clr = 1'b0;
    rsp_set = 1'b0;
    rsp_ack = 1'b0;
    rsp_dat = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_ok) begin
          g_d  = pick;
          load = 1'b1;
        end
      end
      WAIT_ACK: begin
        tmo_d = tmo_q + TW'(1);
        if (m_ack_i) begin
          bus_clr = 1'b1;
          rsp_set = 1'b1;
          rsp_ack = 1'b1;
          rsp_dat = m_we_o ? m_dat_o : m_dat_i;
        end else if (m_err_i || tmo_hit) begin
          bus_clr = 1'b1;
          rsp_set = 1'b1;
        end else if (!g_cyc) begin
          bus_clr = 1'b1;
          rr_d    = g_inc;
        end
      end
      WAIT_NACK: begin
        if (hold_q) begin
          if (!g_stb) begin
            s_ack_d = '0;
            s_err_d = '0;
            s_dat_d = '0;
            hold_d  = 1'b0;
            rr_d    = g_inc;
          end
        end else if (g_req) begin
          load = 1'b1;
        end
      end
      default: ;
    endcase

    if (load) begin
      m_cyc_d = 1'b1;
      m_stb_d = 1'b1;
      m_we_d  = ld_we;
      m_sel_d = ld_sel;
      m_adr_d = ld_adr;
      m_dat_d = ld_dat;
      tmo_d   = '0;
    end

    if (bus_clr) begin
      m_cyc_d = 1'b0;
      m_stb_d = 1'b0;
      m_we_d  = 1'b0;
      m_sel_d = '0;
      m_adr_d = '0;
      m_dat_d = '0;
    end

    if (rsp_set) begin
      hold_d  = 1'b1;
      s_ack_d = '0;
      s_err_d = '0;
      s_dat_d = '0;
      for (int p = 0; p < NMST; p++) begin
        if (PW'(p) == g_q) begin
          s_ack_d[p]           = rsp_ack;
          s_err_d[p]           = ~rsp_ack;
          s_dat_d[p*DW +: DW]  = rsp_dat;
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      g_q     <= '0;
      rr_q    <= '0;
      tmo_q   <= '0;
      hold_q  <= 1'b0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      s_ack_o <= '0;
      s_err_o <= '0;
      s_dat_o <= '0;
      busy_o  <= 1'b0;
    end else begin
      g_q     <= g_d;
      rr_q    <= rr_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      m_cyc_o <= m_cyc_d;
      m_stb_o <= m_stb_d;
      m_we_o  <= m_we_d;
      m_sel_o <= m_sel_d;
      m_adr_o <= m_adr_d;
      m_dat_o <= m_dat_d;
      s_ack_o <= s_ack_d;
      s_err_o <= s_err_d;
      s_dat_o <= s_dat_d;
      busy_o  <= busy_d;
    end
  end

endmodule

// File: tb/tb_io_bridge_arb.sv
// tb_io_bridge_arb: directed and randomized checks of io_bridge_arb against a
// transaction-level model (round-robin pick, expected response and data).
module tb_io_bridge_arb;

  localparam int NM    = 2;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int SW    = 4;
  localparam int TMO_P = 8;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_TMO  = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             gate_en_i;
  logic [NM-1:0]    s_cyc_i, s_stb_i, s_we_i;
  logic [NM*SW-1:0] s_sel_i;
  logic [NM*AW-1:0] s_adr_i;
  logic [NM*DW-1:0] s_dat_i;
  logic [NM-1:0]    s_ack_o, s_err_o;
  logic [NM*DW-1:0] s_dat_o;
  logic             m_cyc_o, m_stb_o, m_we_o;
  logic [SW-1:0]    m_sel_o;
  logic [AW-1:0]    m_adr_o;
  logic [DW-1:0]    m_dat_o;
  logic             m_ack_i, m_err_i;
  logic [DW-1:0]    m_dat_i;
  logic             busy_o;

  int n_vec = 0;
  int n_err = 0;
  int rr_m  = 0;

  logic [AW-1:0] p_adr [NM];
  logic [DW-1:0] p_dat [NM];
  logic          p_we  [NM];
  logic [SW-1:0] p_sel [NM];

  io_bridge_arb #(
    .NMST(NM), .DW(DW), .AW(AW),
    .IO_BASE(32'hFD000000), .IO_MASK(32'hFF000000), .TMO(TMO_P)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .gate_en_i(gate_en_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
    .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_dat_o(s_dat_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_dat_i(m_dat_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input bit cyc, input bit stb, input bit we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sel);
    s_cyc_i[p] = cyc;
    s_stb_i[p] = stb;
    s_we_i[p]  = we;
    s_adr_i[p*AW +: AW] = adr;
    s_dat_i[p*DW +: DW] = dat;
    s_sel_i[p*SW +: SW] = sel;
    p_adr[p] = adr;
    p_dat[p] = dat;
    p_we[p]  = we;
    p_sel[p] = sel;
  endtask

  task automatic idle_all();
    for (int p = 0; p < NM; p++) drive(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Reference arbitration: first wanting port at or after the pointer
  function automatic int rr_pick(input int rr, input logic [NM-1:0] want);
    for (int i = 0; i < NM; i++) begin
      if (want[(rr + i) % NM]) return (rr + i) % NM;
    end
    return 0;
  endfunction

  function automatic logic [63:0] lane(input int g, input logic [31:0] v);
    return 64'(v) << (g * 32);
  endfunction

  // One granted transaction: grant edge, device response, one held cycle
  task automatic txn(input string tag, input int g, input int kind, input int d,
                     input logic [DW-1:0] rdat);
    logic [DW-1:0] exp_dat;
    step();
    chk({tag, "/m_cyc"}, m_cyc_o, 1);
    chk({tag, "/m_stb"}, m_stb_o, 1);
    chk({tag, "/m_adr"}, m_adr_o, p_adr[g]);
    chk({tag, "/m_we"},  m_we_o,  p_we[g]);
    chk({tag, "/m_dat"}, m_dat_o, p_dat[g]);
    chk({tag, "/m_sel"}, m_sel_o, p_sel[g]);
    chk({tag, "/busy"},  busy_o,  1);
    if (kind == K_TMO) begin
      repeat (TMO_P - 1) step();
      chk({tag, "/tmo_wait_cyc"}, m_cyc_o, 1);
      chk({tag, "/tmo_wait_err"}, s_err_o, 0);
      step();
      chk({tag, "/tmo_err"}, s_err_o, 64'(1) << g);
      chk({tag, "/tmo_ack"}, s_ack_o, 0);
      chk({tag, "/tmo_dat"}, s_dat_o, 0);
      chk({tag, "/tmo_cyc"}, m_cyc_o, 0);
    end else begin
      repeat (d) step();
      chk({tag, "/wait_cyc"}, m_cyc_o, 1);
      chk({tag, "/wait_ack"}, s_ack_o | s_err_o, 0);
      m_ack_i = (kind != K_ERR);
      m_err_i = (kind != K_ACK);
      m_dat_i = rdat;
      step();
      m_ack_i = 1'b0;
      m_err_i = 1'b0;
      m_dat_i = '0;
      exp_dat = (kind == K_ERR) ? '0 : (p_we[g] ? p_dat[g] : rdat);
      chk({tag, "/s_ack"}, s_ack_o, (kind != K_ERR) ? (64'(1) << g) : 64'(0));
      chk({tag, "/s_err"}, s_err_o, (kind == K_ERR) ? (64'(1) << g) : 64'(0));
      chk({tag, "/s_dat"}, s_dat_o, lane(g, exp_dat));
      chk({tag, "/bus_clr_cyc"}, m_cyc_o, 0);
      chk({tag, "/bus_clr_adr"}, m_adr_o, 0);
    end
    step();
    chk({tag, "/held"}, s_ack_o | s_err_o, 64'(1) << g);
  endtask

  // Strobe handshake from the granted port; response must clear on that edge
  task automatic rel(input string tag, input int g, input bit keep_cyc);
    s_stb_i[g] = 1'b0;
    s_cyc_i[g] = keep_cyc;
    step();
    chk({tag, "/rel_ack"}, s_ack_o, 0);
    chk({tag, "/rel_err"}, s_err_o, 0);
    chk({tag, "/rel_dat"}, s_dat_o, 0);
    chk({tag, "/rel_cyc"}, m_cyc_o, 0);
    if (!keep_cyc) chk({tag, "/rel_busy"}, busy_o, 0);
    rr_m = (g + 1) % NM;
  endtask

  initial begin
    logic [NM-1:0] want;
    int g, kind, d, r;

    rst_ni = 1'b0;
    gate_en_i = 1'b1;
    s_cyc_i = '0; s_stb_i = '0; s_we_i = '0;
    s_sel_i = '0; s_adr_i = '0; s_dat_i = '0;
    m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst/m_cyc", m_cyc_o, 0);
    chk("rst/m_stb", m_stb_o, 0);
    chk("rst/m_we",  m_we_o,  0);
    chk("rst/m_sel", m_sel_o, 0);
    chk("rst/m_adr", m_adr_o, 0);
    chk("rst/m_dat", m_dat_o, 0);
    chk("rst/s_ack", s_ack_o, 0);
    chk("rst/s_err", s_err_o, 0);
    chk("rst/s_dat", s_dat_o, 0);
    chk("rst/busy",  busy_o,  0);
    rst_ni = 1'b1;
    step();

    // Single read with the device answering in the third cycle
    drive(0, 1, 1, 0, 32'hFD0A0010, 32'h0, 4'hF);
    txn("rd0", rr_pick(rr_m, 2'b01), K_ACK, 2, 32'h12345678);
    rel("rd0", 0, 1'b0);
    step();
    chk("rd0/after_cyc", m_cyc_o, 0);
    chk("rd0/after_busy", busy_o, 0);

    // Out-of-window access must be ignored
    drive(1, 1, 1, 1, 32'hFE000000, 32'hDEADBEEF, 4'hF);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("filter", {m_cyc_o, s_ack_o, s_err_o}, 0);
    end
    idle_all();

    // Grants blocked while gate_en_i is low
    gate_en_i = 1'b0;
    drive(1, 1, 1, 0, 32'hFD001000, 32'h0, 4'hF);
    repeat (3) begin
      step();
      chk("gate/m_cyc", m_cyc_o, 0);
    end
    gate_en_i = 1'b1;

    // Dead device: watchdog error after TMO cycles
    txn("tmo", rr_pick(rr_m, 2'b10), K_TMO, 0, 32'h0);
    rel("tmo", 1, 1'b0);
    idle_all();

    // Abort during WAIT_ACK, then pointer advance past the aborted port
    drive(0, 1, 1, 1, 32'hFD000100, 32'hA5A5A5A5, 4'h3);
    step();
    chk("abort/grant_cyc", m_cyc_o, 1);
    chk("abort/grant_adr", m_adr_o, 32'hFD000100);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(1, 1, 1, 0, 32'hFD000200, 32'h0, 4'hF);
    step();
    chk("abort/cyc",  m_cyc_o, 0);
    chk("abort/resp", s_ack_o | s_err_o, 0);
    chk("abort/busy", busy_o, 0);
    rr_m = 1;
    drive(0, 1, 1, 1, 32'hFD000100, 32'hA5A5A5A5, 4'h3);
    g = rr_pick(rr_m, 2'b11);
    step();
    chk("abort/next_cyc", m_cyc_o, 1);
    chk("abort/next_adr", m_adr_o, p_adr[g]);

    // Asynchronous reset mid-transaction
    step();
    step();
    rst_ni = 1'b0;
    #1;
    chk("mid_rst/m_cyc", m_cyc_o, 0);
    chk("mid_rst/busy",  busy_o, 0);
    idle_all();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    rr_m = 0;
    repeat (3) begin
      step();
      chk("mid_rst/after", {busy_o, m_cyc_o, s_ack_o, s_err_o}, 0);
    end

    // Two ports requesting continuously alternate, starting with port 0
    drive(0, 1, 1, 0, 32'hFD00A000, 32'h0, 4'hF);
    drive(1, 1, 1, 1, 32'hFD00B000, 32'h5555AAAA, 4'hC);
    for (int t = 0; t < 4; t++) begin
      g = rr_pick(rr_m, 2'b11);
      txn($sformatf("rr%0d", t), g, K_ACK, t, $urandom);
      rel($sformatf("rr%0d", t), g, 1'b0);
      drive(g, 1, 1, p_we[g], p_adr[g] + 32'h4, $urandom, p_sel[g]);
    end

    // Device error on a write, then a locked follow-up from the same port
    drive(0, 1, 1, 1, 32'hFD000040, 32'hCAFEF00D, 4'hF);
    g = rr_pick(rr_m, 2'b11);
    txn("rmw_err", g, K_ERR, 1, 32'h0BADBEEF);
    rel("rmw_err", g, 1'b1);
    step();
    chk("rmw/no_interleave", m_cyc_o, 0);
    drive(g, 1, 1, 0, 32'hFD000044, 32'h0, 4'hF);
    txn("rmw_rd", g, K_ACK, 0, 32'h13572468);
    rel("rmw_rd", g, 1'b0);
    g = rr_pick(rr_m, 2'b10);
    txn("rmw_p1", g, K_ACK, 1, 32'h24681357);
    rel("rmw_p1", g, 1'b0);
    idle_all();
    step();

    // Randomized transactions with out-of-window noise on idle ports
    for (int t = 0; t < 40; t++) begin
      want = NM'($urandom_range(1, 3));
      for (int p = 0; p < NM; p++) begin
        if (want[p])
          drive(p, 1, 1, 1'($urandom_range(0, 1)), {8'hFD, 24'($urandom)},
                $urandom, 4'($urandom));
        else if ($urandom_range(0, 2) == 0)
          drive(p, 1, 1, 1'($urandom_range(0, 1)),
                {8'($urandom_range(0, 252)), 24'($urandom)}, $urandom, 4'hF);
      end
      g = rr_pick(rr_m, want);
      r = $urandom_range(0, 9);
      kind = (r == 0) ? K_TMO : (r < 3) ? K_ERR : (r == 3) ? K_BOTH : K_ACK;
      d = $urandom_range(0, 5);
      txn($sformatf("rnd%0d", t), g, kind, d, $urandom);
      rel($sformatf("rnd%0d", t), g, 1'b0);
      idle_all();
      step();
      chk("rnd/idle_gap", m_cyc_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
